// File: rtl/video_pkg.sv
// Shared constants and types for the 15 kHz to 31 kHz scandoubler.
package video_pkg;

    localparam int LINE_LEN  = 448;
    localparam int HS_W      = 54;
    localparam int VS_DET    = 256;
    localparam int BUF_DEPTH = 512;
    localparam int ADDR_W    = 10;
    localparam int RGB_W     = 9;
    localparam int CNT_W     = 9;

    typedef logic [RGB_W-1:0] rgb_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX   = cnt_t'(BUF_DEPTH - 1);
    localparam cnt_t LINE_LAST = cnt_t'(LINE_LEN - 1);
    localparam cnt_t HS_END    = cnt_t'(HS_W);
    localparam cnt_t VS_THRESH = cnt_t'(VS_DET);

    // Counter increment that sticks at the top of the 9-bit range.
    function automatic cnt_t sat_inc(input cnt_t value);
        return (value == CNT_MAX) ? value : value + cnt_t'(1);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Two-bank line store: one write port, one registered read port, no reset on contents.
module line_buffer
    import video_pkg::*;
(
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  rgb_t              wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output rgb_t              rd_data
);

    rgb_t mem [0:2*BUF_DEPTH-1];

    // Write the incoming pixel and register the read data every clock.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/scandoubler.sv
// Writes each ULA line into one bank and replays the other bank twice at the 2x clock.
module scandoubler
    import video_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             ceIn,
    input  logic [1:0]       syncIn,
    input  logic [RGB_W-1:0] rgbIn,
    output logic [RGB_W-1:0] rgbOut,
    output logic             hsyncOut,
    output logic             vsyncOut
);

    logic              csync;
    logic              sync_unused;
    logic              cs_prev;
    logic              line_start;
    logic              w_bank;
    logic              vs_flag;
    logic              vs_line;
    logic              wr_en;
    cnt_t              w_cnt;
    cnt_t              r_cnt;
    cnt_t              r_cnt_d;
    cnt_t              low_cnt;
    cnt_t              low_next;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    rgb_t              rd_data;

    assign csync       = syncIn[0];
    assign sync_unused = syncIn[1];
    assign line_start  = ceIn & cs_prev & ~csync;
    assign wr_en       = ceIn & (w_cnt != CNT_MAX);
    assign wr_addr     = {w_bank, w_cnt};
    assign rd_addr     = {~w_bank, r_cnt};

    // Length of the current csync low run; a falling edge counts as its first pixel.
    always_comb begin
        low_next = '0;
        if (!csync) begin
            low_next = cs_prev ? cnt_t'(1) : sat_inc(low_cnt);
        end
    end

    // Input side: edge detect, write pointer, bank swap and vertical sync detection.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cs_prev <= 1'b1;
            w_bank  <= 1'b0;
            w_cnt   <= '0;
            low_cnt <= '0;
            vs_flag <= 1'b0;
        end else if (ceIn) begin
            cs_prev <= csync;
            low_cnt <= low_next;
            if (line_start) begin
                w_bank <= ~w_bank;
                w_cnt  <= '0;
            end else begin
                w_cnt <= sat_inc(w_cnt);
            end
            if (low_next >= VS_THRESH) begin
                vs_flag <= 1'b1;
            end else if (csync && !cs_prev) begin
                vs_flag <= 1'b0;
            end
        end
    end

    // Read side: free-running line counter, restarted by every input line start.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (line_start || (r_cnt == LINE_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + cnt_t'(1);
        end
    end

    // Output pipeline: syncs are delayed to match the registered RAM read.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt_d  <= '0;
            vs_line  <= 1'b1;
            rgbOut   <= '0;
            hsyncOut <= 1'b1;
            vsyncOut <= 1'b1;
        end else begin
            r_cnt_d  <= r_cnt;
            if (r_cnt == '0) begin
                vs_line <= ~vs_flag;
            end
            rgbOut   <= rd_data;
            hsyncOut <= (r_cnt_d >= HS_END);
            vsyncOut <= vs_line;
        end
    end

    line_buffer u_line_buffer (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (rgbIn),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule
